// File: rtl/mem_stream_reader.sv
// Streams a contiguous address range out of a 1-cycle-latency memory onto a
// valid/ready output, using a 2-entry buffer to absorb read latency under backpressure.
module mem_stream_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   length,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  // Output handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never drops and out_data never changes
  // until that happens.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [DEPTH-1:0] addr;
  logic [DEPTH:0]   issue_left;
  logic [DEPTH:0]   recv_left;
  logic             inflight;
  logic [WIDTH-1:0] buf0, buf1;
  logic [1:0]       count;
  logic [1:0]       occupancy;
  logic             pop, push, issue, accept;

  assign pop           = out_valid & out_ready;
  assign push          = inflight;
  assign out_valid     = (count != 2'd0);
  assign out_data      = buf0;
  assign mem_read_addr = addr;
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign dbg_state     = state;
  assign accept        = (state == IDLE) && start;

  // Projected occupancy once the in-flight word lands; issuing only below 2
  // means a push can never meet a full buffer.
  assign occupancy = count + {1'b0, inflight} - {1'b0, pop};
  assign issue     = (state == RUN) && (issue_left != '0) && (occupancy < 2'd2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (length != '0) ? RUN : DONE;
      RUN:  if (pop && (recv_left == 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      issue_left <= '0;
      recv_left  <= '0;
      inflight   <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      count      <= 2'd0;
    end else begin
      state    <= state_next;
      inflight <= issue;

      if (accept && (length != '0)) begin
        addr       <= base_addr;
        issue_left <= length;
        recv_left  <= length;
      end else begin
        if (issue) begin
          addr       <= addr + 1'b1;
          issue_left <= issue_left - 1'b1;
        end
        if (pop) recv_left <= recv_left - 1'b1;
      end

      // Head is always buf0; buf1 only holds a second word when count==2.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) buf0 <= mem_read_data;
          else               buf1 <= mem_read_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0  <= buf1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0 <= mem_read_data;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: a 1-cycle-latency memory model with
// mem[i] = i + 0x100 and an expected-word queue per transfer.
module tb_mem_stream_reader;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DEPTH-1:0] base_addr;
  logic [DEPTH:0]   length;
  logic             busy, done;
  logic [DEPTH-1:0] mem_read_addr;
  logic [WIDTH-1:0] mem_read_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       dbg_state;

  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  mem_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < (1 << DEPTH); i++) mem[i] = i + 32'h100;

  always @(posedge clk) mem_read_data <= mem[mem_read_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start command; returns 1ns after the edge that samples it.
  task automatic start_cmd(input logic [DEPTH-1:0] b, input logic [DEPTH:0] len);
    start     = 1'b1;
    base_addr = b;
    length    = len;
    tick();
    start = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1,0,1 repeating.
  // exp_done_iter > 0 also checks the cycle on which done appears.
  task automatic xfer(input logic [DEPTH-1:0] b, input int len, input int mode,
                      input int exp_done_iter);
    logic [5:0]       pat = 6'b101001;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               iter = 1;
    int               done_iter = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(b + i) % (1 << DEPTH)]);
    start_cmd(b, len[DEPTH:0]);
    check("first_addr", {24'h0, mem_read_addr}, {24'h0, b});
    while (iter < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : pat[(iter - 1) % 6];
      if (prev_stall) begin
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        check("stall_data", out_data, prev_data);
      end
      if (done) begin
        done_iter = iter;
        check("done_busy", {31'h0, busy}, 32'h0);
        check("done_words_left", exp_q.size(), 32'h0);
        break;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_word", out_data, 32'hDEAD_BEEF);
        else check("word", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      iter++;
    end
    check("done_seen", {31'h0, (done_iter != 0)}, 32'h1);
    if (exp_done_iter > 0) check("done_cycle", done_iter, exp_done_iter);
    tick();
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    int pops;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_addr", {24'h0, mem_read_addr}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    // Basic: first valid two edges after start, done right after the last word.
    out_ready = 1'b1;
    start_cmd(8'h10, 9'd4);
    check("basic_busy", {31'h0, busy}, 32'h1);
    check("basic_valid_lat1", {31'h0, out_valid}, 32'h0);
    tick();
    check("basic_valid_lat2", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("basic_valid", {31'h0, out_valid}, 32'h1);
      check("basic_word", out_data, 32'h110 + i);
    end
    tick();
    check("basic_done", {31'h0, done}, 32'h1);
    check("basic_done_busy", {31'h0, busy}, 32'h0);
    check("basic_done_valid", {31'h0, out_valid}, 32'h0);
    tick();
    check("basic_done_end", {31'h0, done}, 32'h0);

    // Zero length: address holds at 0x14, done the cycle after start.
    start_cmd(8'h55, 9'd0);
    check("zero_done", {31'h0, done}, 32'h1);
    check("zero_busy", {31'h0, busy}, 32'h0);
    check("zero_valid", {31'h0, out_valid}, 32'h0);
    check("zero_addr", {24'h0, mem_read_addr}, 32'h14);
    tick();
    check("zero_done_end", {31'h0, done}, 32'h0);
    check("zero_addr2", {24'h0, mem_read_addr}, 32'h14);

    xfer(8'hFE, 4, 0, 7);       // wrap: FE, FF, 00, 01
    xfer(8'h30, 8, 1, 0);       // backpressure
    xfer(8'h00, 256, 0, 259);   // full range at one word per cycle

    // Reset after three words have been accepted.
    start_cmd(8'h40, 9'd8);
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 20 && pops < 3; i++) begin
      if (out_valid) begin
        check("mid_word", out_data, 32'h140 + pops);
        pops++;
      end
      if (pops < 3) tick();
    end
    check("mid_pops", pops, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    tick();
    check("mid_rst_no_done", {31'h0, done}, 32'h0);
    check("mid_rst_no_valid", {31'h0, out_valid}, 32'h0);
    xfer(8'h20, 2, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side initiator for the team's simple dual-port memory. That memory registers its read address on the clock edge and returns data one cycle later.
- On a start command, the block walks a contiguous address range and issues one read per cycle when it is allowed to.
- Returned words are presented on a valid/ready output stream, with a 2-entry buffer that absorbs the 1-cycle read latency under backpressure.
- Sits between any memory instance and a streaming consumer (e.g. serializer, DMA sink).

Parameters:
- DEPTH, 8, memory address width in bits (2**DEPTH words).
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  DEPTH  first address; sampled with start.
- length  input  DEPTH+1  word count, 0..2**DEPTH; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of transfer.
- mem_read_addr  output  DEPTH  address to the memory read port.
- mem_read_data  input  WIDTH  memory read data, valid the cycle after the address was presented.
- out_data  output  WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from consumer.

Behaviour:
- Reset (synchronous, rst=1 at posedge)
  - State = IDLE; busy=0, done=0, out_valid=0, out_data=0, mem_read_addr=0.
  - Buffer emptied, in-flight flag cleared, counters cleared.
  - Reset mid-transfer abandons it with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 with length>0: latch addr=base_addr, issue_left=length, recv_left=length; go to RUN.
  - start=1 with length=0: go to DONE, no reads issued.
  - start in any other state is ignored.
- RUN (busy=1)
  - A read is issued in a cycle when issue_left>0 and (count + inflight - pop) < 2.
    - count = buffer occupancy (0..2); inflight = a read issued last cycle; pop = out_valid & out_ready.
  - mem_read_addr is driven from the addr register at all times. "Issue" means addr and issue_left advance at this edge, and inflight=1 next cycle.
  - When inflight=1, mem_read_data is pushed into the buffer that cycle.
  - Buffer is FIFO ordered. out_data/out_valid reflect the head entry.
  - Push and pop in the same cycle are both honoured.
  - Address increments modulo 2**DEPTH: base 0xFE, length 4 reads FE, FF, 00, 01.
  - recv_left decrements on each pop. The pop that takes it to 0 moves state to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Throughput: with out_ready held high, one word per cycle after an initial latency of 2 cycles from the start edge to first out_valid (issue edge, then data registered into the buffer).
- Backpressure
  - out_valid, once high, stays high with out_data stable until accepted.
  - No word is lost or duplicated; at most 2 words are buffered.
  - The credit rule guarantees a push never meets a full buffer.
- mem_read_addr holds its last value while idle. The memory may be written concurrently; the block returns whatever the memory presents.

Test Plan:
- Memory preloaded mem[i]=i+0x100; start, base=0x10, length=4, out_ready=1 -> out_data 0x110, 0x111, 0x112, 0x113 on consecutive cycles; first out_valid 2 cycles after the start edge; done pulses the cycle after the last handshake; busy low with done.
- Wrap-around: base=0xFE, length=4 (DEPTH=8) -> mem_read_addr sequence FE, FF, 00, 01; data in that order.
- Backpressure: length=8, out_ready toggled 1,0,0,1,0,1... -> all 8 words delivered in order, none dropped or repeated; out_data stable while out_valid=1 and out_ready=0; buffer occupancy never exceeds 2.
- length=0 start -> no address advance, no out_valid, done pulses one cycle after start, busy stays 0.
- Full length=256 from base=0 with out_ready=1 -> 256 words, throughput 1 per cycle after fill, done once.
- rst asserted mid-transfer (after 3 of 8 words) -> next cycle out_valid=0, busy=0, no done. A new start with base=0x20, length=2 then returns mem[0x20], mem[0x21] only.
